// File: rtl/lpf_decim_pkg.sv
// Shared constants and sample helpers for the decimate-by-2 stream stage.
package lpf_decim_pkg;

  localparam int NBITS_C = 12;
  localparam int NSAMP_C = 8;
  localparam int LANE_W  = 16;
  localparam int IN_W    = NBITS_C * NSAMP_C;
  localparam int OUT_W   = LANE_W * NSAMP_C;

  // Extract two's-complement sample i from a packed filter word.
  function automatic logic signed [NBITS_C-1:0] sample_at(input logic [IN_W-1:0] v, input int i);
    return v[NBITS_C*i +: NBITS_C];
  endfunction

  // Place each 12-bit sample in the top of a 16-bit lane; low nibble is zero.
  function automatic logic [OUT_W-1:0] pack12to16(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int j = 0; j < NSAMP_C; j++) begin
      r[LANE_W*j +: LANE_W] = {sample_at(v, j), 4'b0000};
    end
    return r;
  endfunction

endpackage

// File: rtl/lpf_decim2_stream_fifo.sv
// Small synchronous FIFO with a registered first-word-fall-through head.
// A push into a full FIFO is accepted only when the head is popped that cycle.
module decim_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 129
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         rdy_i,
  output logic [W-1:0] data_o,
  output logic         vld_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  out_q, out_d;
  logic          vld_q, vld_d;
  logic          pop, push_ok;

  // Pointer/occupancy update and next head selection (bypass when the new head is being written).
  always_comb begin
    full_o  = (cnt_q == (AW+1)'(DEPTH));
    empty_o = (cnt_q == '0);
    pop     = vld_q & rdy_i;
    push_ok = push_i & (~full_o | pop);
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push_ok);
    cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    vld_d   = (cnt_d != '0);
    out_d   = out_q;
    if (cnt_d != '0) begin
      out_d = (push_ok && (wr_q == rd_d)) ? push_data_i : mem_q[rd_d];
    end
  end

  // Control state and registered head; head resets to zero so outputs are clean after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
      out_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      out_q <= out_d;
    end
  end

  // Storage array, data only.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= push_data_i;
  end

  assign data_o = out_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/lpf_decim2_stream.sv
// Keeps the even samples of every other filter output cycle and packs two
// half-beats into one 128-bit stream beat, with frame marker and drop counting.
module lpf_decim2_stream
  import lpf_decim_pkg::*;
#(
  parameter int NBITS       = 12,
  parameter int NSAMP       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_BEATS = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [NBITS*NSAMP-1:0] in_i,
  output logic [16*NSAMP-1:0]    dec_tdata,
  output logic                   dec_tvalid,
  input  logic                   dec_tready,
  output logic                   dec_tlast,
  output logic                   ovf_o,
  output logic [15:0]            ovf_cnt_o,
  input  logic                   ovf_clr_i
);

  localparam int HALF_W = NBITS * NSAMP / 2;
  localparam int FCW    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_BEATS - 1);

  logic              ph_q, ph_d;
  logic [HALF_W-1:0] hold_q, hold_d;
  logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       ovf_cnt_q, ovf_cnt_d;
  logic              beat_vld, beat_last;
  logic [IN_W-1:0]   beat_samp;
  logic [OUT_W:0]    fifo_in, fifo_out;
  logic              fifo_full, fifo_empty, fifo_pop, drop;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Phase toggle, half-beat capture and beat assembly.
  always_comb begin
    ph_d     = 1'b0;
    hold_d   = hold_q;
    beat_vld = 1'b0;
    if (en_i) begin
      ph_d = ~ph_q;
      if (!ph_q) begin
        for (int j = 0; j < NSAMP/2; j++) hold_d[NBITS*j +: NBITS] = sample_at(in_i, 2*j);
      end else begin
        beat_vld = 1'b1;
      end
    end
    beat_samp = '0;
    for (int j = 0; j < NSAMP/2; j++) begin
      beat_samp[NBITS*j +: NBITS]             = hold_q[NBITS*j +: NBITS];
      beat_samp[NBITS*(j+NSAMP/2) +: NBITS] = sample_at(in_i, 2*j);
    end
  end

  // Frame position advances on every produced beat, stored or dropped.
  always_comb begin
    beat_last   = (frame_cnt_q == FRAME_LAST);
    frame_cnt_d = en_i ? frame_cnt_q : '0;
    if (beat_vld) frame_cnt_d = beat_last ? '0 : frame_cnt_q + FCW'(1);
  end

  // Drop detection and sticky/saturating overflow bookkeeping.
  always_comb begin
    fifo_pop  = ~fifo_empty & dec_tready;
    drop      = beat_vld & fifo_full & ~fifo_pop;
    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;
    if (drop) begin
      ovf_d     = 1'b1;
      ovf_cnt_d = ovf_clr_i ? 16'd1 : sat_inc16(ovf_cnt_q);
    end else if (ovf_clr_i) begin
      ovf_d     = 1'b0;
      ovf_cnt_d = '0;
    end
  end

  // Control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q        <= 1'b0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      ph_q        <= ph_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  // Held half-beat; stale content is harmless because phase 0 always rewrites it.
  always_ff @(posedge clk_i) begin
    hold_q <= hold_d;
  end

  assign fifo_in = {beat_last, pack12to16(beat_samp)};

  decim_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (OUT_W + 1)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (beat_vld),
    .push_data_i (fifo_in),
    .rdy_i       (dec_tready),
    .data_o      (fifo_out),
    .vld_o       (dec_tvalid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign dec_tdata = fifo_out[OUT_W-1:0];
  assign dec_tlast = fifo_out[OUT_W];
  assign ovf_o     = ovf_q;
  assign ovf_cnt_o = ovf_cnt_q;

endmodule

// File: tb/tb_lpf_decim2_stream.sv
// Directed bench for lpf_decim2_stream.
module tb_lpf_decim2_stream;

  logic         clk = 1'b0;
  logic         rst, en, tready, clr;
  logic [95:0]  din;
  logic [127:0] tdata;
  logic         tvalid, tlast, ovf;
  logic [15:0]  ovf_cnt;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  lpf_decim2_stream #(
    .NBITS(12), .NSAMP(8), .FIFO_DEPTH(4), .FRAME_BEATS(64)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .in_i       (din),
    .dec_tdata  (tdata),
    .dec_tvalid (tvalid),
    .dec_tready (tready),
    .dec_tlast  (tlast),
    .ovf_o      (ovf),
    .ovf_cnt_o  (ovf_cnt),
    .ovf_clr_i  (clr)
  );

  function automatic logic [95:0] ramp_in(input int c);
    logic [95:0] v;
    for (int i = 0; i < 8; i++) v[12*i +: 12] = 12'(8*c + i);
    return v;
  endfunction

  // Beat k = even samples of ramp cycles 2k and 2k+1: lane j = (16k+2j) mod 4096.
  function automatic logic [127:0] ramp_beat(input int k);
    logic [127:0] r;
    for (int j = 0; j < 8; j++) r[16*j +: 16] = {12'(16*k + 2*j), 4'h0};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; tready = 1'b0; clr = 1'b0; din = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; tready = 1'b0; clr = 1'b0; din = '0;
    tick();
    tick();
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    checks++; if (tdata !== 128'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", tdata); end
    checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", tlast); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (ovf_cnt !== 16'h0) begin errors++; $display("FAIL reset_ovf_cnt got %0d want 0", ovf_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ramp();
    int k;
    do_reset();
    tready = 1'b1;
    k = 0;
    for (int c = 0; c < 24; c++) begin
      en = 1'b1; din = ramp_in(c);
      if (c < 2) begin
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL ramp_early_valid c=%0d got %b want 0", c, tvalid); end
      end
      if (c == 2) begin
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL ramp_first_valid got %b want 1", tvalid); end
      end
      if (tvalid === 1'b1) begin
        checks++; if (tdata !== ramp_beat(k)) begin errors++; $display("FAIL ramp_data beat %0d got %h want %h", k, tdata, ramp_beat(k)); end
        checks++; if (c != 2 + 2*k) begin errors++; $display("FAIL ramp_timing beat %0d at cycle %0d want %0d", k, c, 2 + 2*k); end
        k++;
      end
      tick();
    end
    checks++; if (k != 11) begin errors++; $display("FAIL ramp_count got %0d want 11", k); end
    checks++; if (ovf_cnt !== 16'h0) begin errors++; $display("FAIL ramp_ovf_cnt got %0d want 0", ovf_cnt); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_negative();
    int k;
    logic [127:0] exp_b;
    exp_b = {{4{16'h8000}}, {4{16'hFFF0}}};
    do_reset();
    tready = 1'b1;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      en = 1'b1;
      din = (c % 2 == 0) ? {8{12'hFFF}} : {8{12'h800}};
      if (tvalid === 1'b1) begin
        checks++; if (tdata !== exp_b) begin errors++; $display("FAIL neg_data beat %0d got %h want %h", k, tdata, exp_b); end
        k++;
      end
      tick();
    end
    checks++; if (k != 9) begin errors++; $display("FAIL neg_count got %0d want 9", k); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_frames();
    int k;
    do_reset();
    tready = 1'b1;
    k = 0;
    for (int c = 0; c < 258; c++) begin
      en = 1'b1; din = ramp_in(c);
      if (tvalid === 1'b1) begin
        checks++; if (tlast !== ((k == 63) || (k == 127))) begin errors++; $display("FAIL frame_tlast beat %0d got %b want %b", k, tlast, (k == 63) || (k == 127)); end
        k++;
      end
      tick();
    end
    checks++; if (k != 128) begin errors++; $display("FAIL frame_count got %0d want 128", k); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int exp_k [5] = '{0, 1, 2, 3, 10};
    int n;
    do_reset();
    tready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      en = 1'b1; din = ramp_in(c);
      if (c == 9) begin
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_before_drop got %b want 0", ovf); end
      end
      if (c == 10) begin
        checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL bp_first_drop_cnt got %0d want 1", ovf_cnt); end
      end
      tick();
    end
    checks++; if (ovf_cnt !== 16'd6) begin errors++; $display("FAIL bp_ovf_cnt got %0d want 6", ovf_cnt); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b want 1", ovf); end
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL bp_valid_held got %b want 1", tvalid); end
    tready = 1'b1;
    n = 0;
    for (int c = 20; c < 30; c++) begin
      en = 1'b1; din = ramp_in(c);
      if (tvalid === 1'b1 && n < 5) begin
        checks++; if (tdata !== ramp_beat(exp_k[n])) begin errors++; $display("FAIL bp_order pop %0d got %h want beat %0d %h", n, tdata, exp_k[n], ramp_beat(exp_k[n])); end
        n++;
      end
      tick();
    end
    checks++; if (n != 5) begin errors++; $display("FAIL bp_pop_count got %0d want 5", n); end

    // Clear coinciding with a drop, then a plain clear.
    do_reset();
    tready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      en = 1'b1; din = ramp_in(c);
      clr = (c == 19);
      tick();
    end
    checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL clr_with_drop_cnt got %0d want 1", ovf_cnt); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL clr_with_drop_ovf got %b want 1", ovf); end
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", ovf_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", ovf); end
  endtask

  task automatic test_enable_glitch();
    logic [95:0]  a_w, b_w, c_w;
    logic [127:0] exp_b;
    for (int i = 0; i < 8; i++) begin
      a_w[12*i +: 12] = 12'h100 + 12'(i);
      b_w[12*i +: 12] = 12'h200 + 12'(i);
      c_w[12*i +: 12] = 12'h300 + 12'(i);
    end
    for (int j = 0; j < 4; j++) begin
      exp_b[16*j +: 16]     = {12'h200 + 12'(2*j), 4'h0};
      exp_b[16*(j+4) +: 16] = {12'h300 + 12'(2*j), 4'h0};
    end
    do_reset();
    tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0:       begin en = 1'b1; din = a_w; end
        4:       begin en = 1'b1; din = b_w; end
        5:       begin en = 1'b1; din = c_w; end
        default: begin en = 1'b0; din = {8{12'h777}}; end
      endcase
      if (c >= 1 && c <= 5) begin
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL glitch_no_beat c=%0d got %b want 0", c, tvalid); end
      end
      if (c == 6) begin
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL glitch_valid got %b want 1", tvalid); end
        checks++; if (tdata !== exp_b) begin errors++; $display("FAIL glitch_data got %h want %h", tdata, exp_b); end
      end
      if (c == 7) begin
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL glitch_single got %b want 0", tvalid); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midburst();
    int k;
    do_reset();
    tready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      en = 1'b1; din = ramp_in(c);
      tick();
    end
    tready = 1'b1; en = 1'b1; din = ramp_in(10);
    tick();
    tready = 1'b0; en = 1'b1; din = ramp_in(11);
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", tvalid); end
    checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL mid_pre_cnt got %0d want 1", ovf_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", tvalid); end
    checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", ovf_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got %b want 0", ovf); end
    tready = 1'b1;
    k = 0;
    for (int c = 0; c < 130; c++) begin
      en = 1'b1; din = ramp_in(c);
      if (tvalid === 1'b1) begin
        if (k == 0) begin
          checks++; if (tdata !== ramp_beat(0)) begin errors++; $display("FAIL mid_first_data got %h want %h", tdata, ramp_beat(0)); end
        end
        checks++; if (tlast !== (k == 63)) begin errors++; $display("FAIL mid_tlast beat %0d got %b want %b", k, tlast, k == 63); end
        k++;
      end
      tick();
    end
    checks++; if (k != 64) begin errors++; $display("FAIL mid_count got %0d want 64", k); end
    en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_frames();
    test_backpressure();
    test_enable_glitch();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
